taxi_axis_frame_trunc: RTL
==========================

// Module: taxi_axis_frame_trunc
// PURPOSE
// - AXI4-Stream frame length limiter; sits directly downstream of the AXI4-Stream pipeline FIFO on long-haul RX paths.
// - Frames up to MAX_LEN bytes pass unchanged.
// - A longer frame is cut at MAX_LEN bytes, its last emitted beat is flagged in tuser, and the remainder is dropped.
// - Keeps a saturating count of truncated frames for CSR readout.
// PARAMETERS
// - MAX_LEN  1518  maximum emitted frame length in bytes, >= 1
// - ERR_BIT  0     tuser bit index set on a truncated frame's last beat; must be < USER_W
// - CNT_W    32    truncation counter width
// - DATA_W, KEEP_W, USER_W, ID_W, DEST_W come from the s_axis interface; m_axis must match (elaboration $fatal otherwise).
// PORTS
// - One clock; reset is asynchronous and active-low.
// - clk         in   1      clock
// - rst_n       in   1      async active-low reset
// - s_axis      snk  if     taxi_axis_if input stream
// - m_axis      src  if     taxi_axis_if output stream
// - trunc_cnt   out  CNT_W  saturating count of truncated frames
// - trunc_evt   out  1      one-cycle pulse when a truncated last beat is emitted
// BEHAVIOUR
// - Reset values: m_axis.tvalid=0, s_axis.tready=0, trunc_cnt=0, trunc_evt=0, state=PASS, byte count=0.
// - s_axis.tready rises on the first clk edge after rst_n deasserts.
// - Reset asserted mid-frame discards all held beats; output resumes at the next frame start.
// - Output uses a 2-entry skid register: 1-cycle latency, full throughput.
// - s_axis.tready is registered: it equals "skid entry free".
// - No m_axis field may change while tvalid=1 && !tready.
// - Byte counting:
//   - beat_bytes = popcount(tkeep), or KEEP_W when KEEP_EN=0.
//   - Byte counter width = $clog2(MAX_LEN+KEEP_W+1).
//   - room = MAX_LEN - count.
// - State PASS (on accept):
//   - beat_bytes < room, or beat_bytes == room with tlast: forward unchanged. count += beat_bytes, or count=0 if tlast.
//   - beat_bytes == room with !tlast: forward with tlast forced to 1 and tuser[ERR_BIT]=1; -> DROP.
//   - beat_bytes > room: forward with tkeep masked to the low `room` bytes, tlast=1, tuser[ERR_BIT]=1; -> DROP if !tlast, else stay in PASS. count=0.
// - State DROP:
//   - tready follows the skid-free rule; accepted beats are consumed without being forwarded.
//   - tlast accepted -> PASS, count=0.
// - trunc_evt pulses, and trunc_cnt increments (saturating at all-ones), on the cycle the flagged beat is written into the skid register. This happens once per frame.
// - tid, tdest, and the other tuser bits pass through. A forced last beat keeps that beat's tid/tdest.
// - tkeep must be low-contiguous. The masked tkeep is {KEEP_W{1}} >> (KEEP_W-room).
// - LAST_EN=0 on s_axis: every beat is its own frame. Truncation then applies per beat when KEEP_W > MAX_LEN.
// STRUCTURE
// - Package taxi_axis_trunc_pkg: typedef enum logic {PASS, DROP} trunc_state_t; function popcount_keep().
// - Sub-module taxi_axis_skid_reg: a 2-entry async-reset (rst_n) skid register carrying the whole stream bundle.
//   - It is the natural split and is reused by other async-reset stages.
// - The top level holds the FSM, byte counter, keep masking and status counter. Target 200-300 lines total.
// TESTING
// - 64-bit bus, MAX_LEN=16, a 16-byte frame (2 full beats, tlast on beat 2) -> forwarded unchanged, tuser[0]=0, trunc_cnt=0.
// - 20-byte frame (beats of 8, 8, 4 bytes) -> 2 beats out, beat 2 has tlast=1 and tuser[0]=1, third beat dropped, trunc_evt pulses once, trunc_cnt=1.
// - 12-byte frame with tkeep 0xFF then 0x0F, MAX_LEN=10 -> beat 2 tkeep=0x03, tlast=1, tuser[0]=1; next frame passes intact.
// - Random m_axis.tready (50%) over 1000 mixed-length frames -> output matches a golden model, no held-beat changes, trunc_cnt equals the count of long frames.
// - rst_n pulsed low while in DROP mid-frame -> tvalid=0 immediately; the following frame is forwarded unmodified from its first beat.
// - CNT_W=2 with 5 long frames -> trunc_cnt saturates at 3, trunc_evt pulses 5 times.

Source files
------------

// File: rtl/taxi_axis_trunc_pkg.sv
// Shared types and helpers for the AXI4-Stream frame length limiter.
package taxi_axis_trunc_pkg;

    // Frame handling state: forwarding beats, or discarding the tail of a cut frame
    typedef enum logic {
        PASS = 1'b0,
        DROP = 1'b1
    } trunc_state_t;

    // Widest tkeep the byte counter helper accepts
    localparam int KEEP_MAX_W = 128;

    // Number of set bits in a tkeep vector (zero-extended to KEEP_MAX_W)
    function automatic logic [7:0] popcount_keep(input logic [KEEP_MAX_W-1:0] keep);
        logic [7:0] n;
        n = 8'd0;
        for (int i = 0; i < KEEP_MAX_W; i++) begin
            n = n + {7'd0, keep[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/taxi_axis_if.sv
// AXI4-Stream interface bundle with source and sink views.
interface taxi_axis_if #(
    parameter int   DATA_W  = 8,
    parameter logic KEEP_EN = (DATA_W > 8),
    parameter int   KEEP_W  = ((DATA_W + 7) / 8),
    parameter logic LAST_EN = 1'b1,
    parameter logic ID_EN   = 1'b0,
    parameter int   ID_W    = 8,
    parameter logic DEST_EN = 1'b0,
    parameter int   DEST_W  = 8,
    parameter logic USER_EN = 1'b0,
    parameter int   USER_W  = 1
);
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [ID_W-1:0]   tid;
    logic [DEST_W-1:0] tdest;
    logic [USER_W-1:0] tuser;

    modport src (output tdata, tkeep, tvalid, tlast, tid, tdest, tuser, input tready);
    modport snk (input tdata, tkeep, tvalid, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/taxi_axis_skid_reg.sv
// Two-entry skid register: one-cycle latency, full throughput, registered
// input ready. The output beat never changes while it is stalled.
module taxi_axis_skid_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    output logic [W-1:0] out_data_o,
    output logic         out_valid_o,
    input  logic         out_ready_i
);

    logic [W-1:0] out_data_q, out_data_d;
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] skid_data_q, skid_data_d;
    logic         skid_valid_q, skid_valid_d;
    logic         in_ready_q;
    logic         acc_s;

    // Next-state of the output and skid entries
    always_comb begin
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        skid_data_d  = skid_data_q;
        skid_valid_d = skid_valid_q;
        acc_s        = in_valid_i && in_ready_q;
        if (skid_valid_q) begin
            // Skid holds a beat: promote it as soon as the output drains
            if (out_ready_i) begin
                out_data_d   = skid_data_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                skid_valid_d = 1'b1;
            end
        end else if (out_ready_i || !out_valid_q) begin
            // Output slot is free this cycle: load it directly
            out_valid_d = acc_s;
            if (acc_s) begin
                out_data_d = in_data_i;
            end else begin
                out_data_d = out_data_q;
            end
        end else if (acc_s) begin
            // Output stalled: park the new beat in the skid entry
            skid_data_d  = in_data_i;
            skid_valid_d = 1'b1;
        end else begin
            skid_valid_d = 1'b0;
        end
    end

    // Storage registers; ready is registered as "skid entry free"
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            skid_data_q  <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            skid_data_q  <= skid_data_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= !skid_valid_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;

endmodule

// File: rtl/taxi_axis_frame_trunc.sv
// AXI4-Stream frame length limiter. Frames longer than MAX_LEN bytes are cut,
// the last emitted beat is flagged in tuser[ERR_BIT], and the tail is dropped.
module taxi_axis_frame_trunc
    import taxi_axis_trunc_pkg::*;
#(
    parameter int MAX_LEN = 1518,
    parameter int ERR_BIT = 0,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    taxi_axis_if.snk         s_axis,
    taxi_axis_if.src         m_axis,
    output logic [CNT_W-1:0] trunc_cnt,
    output logic             trunc_evt
);

    localparam int   DATA_W  = s_axis.DATA_W;
    localparam int   KEEP_W  = s_axis.KEEP_W;
    localparam logic KEEP_EN = s_axis.KEEP_EN;
    localparam logic LAST_EN = s_axis.LAST_EN;
    localparam int   ID_W    = s_axis.ID_W;
    localparam int   DEST_W  = s_axis.DEST_W;
    localparam int   USER_W  = s_axis.USER_W;
    localparam int   CW      = $clog2(MAX_LEN + KEEP_W + 1);
    localparam int   BW      = DATA_W + KEEP_W + 1 + ID_W + DEST_W + USER_W;

    if (m_axis.DATA_W != DATA_W || m_axis.KEEP_W != KEEP_W || m_axis.ID_W != ID_W ||
        m_axis.DEST_W != DEST_W || m_axis.USER_W != USER_W) begin : g_err_if
        $fatal(1, "taxi_axis_frame_trunc: m_axis parameters do not match s_axis");
    end
    if (ERR_BIT >= USER_W || MAX_LEN < 1 || KEEP_W > KEEP_MAX_W) begin : g_err_param
        $fatal(1, "taxi_axis_frame_trunc: invalid ERR_BIT, MAX_LEN or KEEP_W");
    end

    trunc_state_t      state_q;
    logic [CW-1:0]     count_q;
    logic [CNT_W-1:0]  trunc_cnt_q;
    logic              trunc_evt_q;

    logic [CW-1:0]     beat_bytes_s;
    logic [CW-1:0]     room_s;
    logic [KEEP_W-1:0] keep_mask_s;
    logic [KEEP_W-1:0] out_keep_s;
    logic [USER_W-1:0] out_user_s;
    logic              last_in_s;
    logic              out_last_s;
    logic              over_s;
    logic              cut_s;
    logic              accept_s;
    logic              skid_ready_s;
    logic              skid_valid_s;
    logic [BW-1:0]     skid_in_s;
    logic [BW-1:0]     skid_out_s;

    // Classify the incoming beat against the remaining byte budget and shape it
    always_comb begin
        if (KEEP_EN) begin
            beat_bytes_s = CW'(popcount_keep(KEEP_MAX_W'(s_axis.tkeep)));
        end else begin
            beat_bytes_s = CW'(KEEP_W);
        end
        if (LAST_EN) begin
            last_in_s = s_axis.tlast;
        end else begin
            last_in_s = 1'b1;
        end
        room_s      = CW'(MAX_LEN) - count_q;
        // Only meaningful when the beat overflows, i.e. room < beat_bytes <= KEEP_W
        keep_mask_s = {KEEP_W{1'b1}} >> (CW'(KEEP_W) - room_s);
        over_s      = beat_bytes_s > room_s;
        cut_s       = over_s || ((beat_bytes_s == room_s) && !last_in_s);
        if (over_s) begin
            out_keep_s = keep_mask_s;
        end else begin
            out_keep_s = s_axis.tkeep;
        end
        out_user_s = s_axis.tuser;
        if (cut_s) begin
            out_user_s[ERR_BIT] = 1'b1;
        end else begin
            out_user_s[ERR_BIT] = s_axis.tuser[ERR_BIT];
        end
        out_last_s = last_in_s || cut_s;
    end

    assign accept_s     = s_axis.tvalid && skid_ready_s;
    assign skid_valid_s = s_axis.tvalid && (state_q == PASS);
    assign skid_in_s    = {s_axis.tdata, out_keep_s, out_last_s, s_axis.tid, s_axis.tdest, out_user_s};

    // Frame FSM, byte counter and saturating truncation statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= PASS;
            count_q     <= '0;
            trunc_cnt_q <= '0;
            trunc_evt_q <= 1'b0;
        end else begin
            trunc_evt_q <= 1'b0;
            if (accept_s) begin
                case (state_q)
                    PASS: begin
                        if (cut_s) begin
                            count_q     <= '0;
                            trunc_evt_q <= 1'b1;
                            if (trunc_cnt_q != '1) begin
                                trunc_cnt_q <= trunc_cnt_q + CNT_W'(1);
                            end
                            if (last_in_s) begin
                                state_q <= PASS;
                            end else begin
                                state_q <= DROP;
                            end
                        end else if (last_in_s) begin
                            count_q <= '0;
                        end else begin
                            count_q <= count_q + beat_bytes_s;
                        end
                    end
                    DROP: begin
                        if (last_in_s) begin
                            state_q <= PASS;
                            count_q <= '0;
                        end
                    end
                    default: begin
                        state_q <= PASS;
                        count_q <= '0;
                    end
                endcase
            end
        end
    end

    taxi_axis_skid_reg #(
        .W(BW)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data_i  (skid_in_s),
        .in_valid_i (skid_valid_s),
        .in_ready_o (skid_ready_s),
        .out_data_o (skid_out_s),
        .out_valid_o(m_axis.tvalid),
        .out_ready_i(m_axis.tready)
    );

    assign s_axis.tready = skid_ready_s;
    assign {m_axis.tdata, m_axis.tkeep, m_axis.tlast, m_axis.tid, m_axis.tdest, m_axis.tuser} = skid_out_s;
    assign trunc_cnt = trunc_cnt_q;
    assign trunc_evt = trunc_evt_q;

endmodule
